// File: rtl/seq_mul.sv
// Iterative shift-add 32x32 multiplier for UMUL/SMUL(cc).
// One partial-product step per clock; the product low word feeds writeback, the high word feeds Y.
module seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             icc_n,
    output logic             icc_z
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;

    logic             w_accept;
    logic             w_last;
    logic             w_finish;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_acc_step;
    logic [PW-1:0]    w_product;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_finish = (r_state == S_RUN) && w_last && !flush;

    // Signed operands are reduced to magnitudes; 2^(WIDTH-1) still fits unsigned
    assign w_mag_a = (signed_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign w_mag_b = (signed_op && b[WIDTH-1]) ? WIDTH'(-b) : b;

    // One shift-add step: carry-keeping add into the upper half, then shift right
    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_step = PW'({w_sum, r_acc[WIDTH-1:0]} >> 1);
    assign w_product  = r_neg ? (-w_acc_step) : w_acc_step;

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= w_mag_a;
            r_mplr  <= w_mag_b;
            r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if ((r_state == S_RUN) && !flush) begin
            r_acc   <= w_acc_step;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Results are written only on the final step, so they are valid throughout FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            icc_n     <= 1'b0;
            icc_z     <= 1'b0;
        end else begin
            busy <= (w_next_state != S_IDLE);
            done <= w_finish;
            if (w_finish) begin
                result_lo <= w_product[WIDTH-1:0];
                result_hi <= w_product[PW-1:WIDTH];
                icc_n     <= w_product[WIDTH-1];
                icc_z     <= (w_product[WIDTH-1:0] == '0);
            end
        end
    end

endmodule
